// File: rtl/control_sequencer_pkg.sv
// Shared CPU constants: word/opcode widths, load-target and ALU encodings,
// opcode map and the registered control-output bundle.
package control_sequencer_pkg;

  localparam int WORD_SIZE = 19;
  localparam int OPCODE_W  = 5;

  typedef enum logic [1:0] {
    LOAD_NONE = 2'd0,
    LOAD_IR   = 2'd1,
    LOAD_PC   = 2'd2,
    LOAD_ACC  = 2'd3
  } load_sel_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4
  } alu_op_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 5'h00,
    OP_LOAD  = 5'h01,
    OP_STORE = 5'h02,
    OP_ADD   = 5'h03,
    OP_SUB   = 5'h04,
    OP_AND   = 5'h05,
    OP_OR    = 5'h06,
    OP_JMP   = 5'h07,
    OP_JZ    = 5'h08,
    OP_HALT  = 5'h1F
  } opcode_t;

  typedef struct packed {
    logic      load_reg;
    load_sel_t load_sel;
    logic      addr_sel;
    logic      mem_rd;
    logic      mem_wr;
    logic      pc_inc;
    alu_op_t   alu_op;
    logic      halted;
    logic      trap;
  } ctrl_out_t;

  // ALU operation for an accumulator writeback; anything non-arithmetic passes.
  function automatic alu_op_t alu_of(input logic [OPCODE_W-1:0] op);
    alu_op_t r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_sequencer_op_classifier.sv
// Combinational opcode classifier: memory operand, store, ALU, jump, illegal.
module op_classifier
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W = control_sequencer_pkg::OPCODE_W
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_mem,
  output logic                is_store,
  output logic                is_alu,
  output logic                is_jump,
  output logic                is_illegal
);

  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_alu     = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPCODE_W'(OP_NOP), OPCODE_W'(OP_HALT): ;
      OPCODE_W'(OP_LOAD): is_mem = 1'b1;
      OPCODE_W'(OP_STORE): begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND), OPCODE_W'(OP_OR): begin
        is_mem = 1'b1;
        is_alu = 1'b1;
      end
      OPCODE_W'(OP_JMP), OPCODE_W'(OP_JZ): is_jump = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// CPU control sequencer: fetch / decode / memory / writeback FSM with
// registered outputs. Define ILLEGAL_OP_TRAP_EN to trap on unlisted opcodes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = control_sequencer_pkg::WORD_SIZE,
  parameter int OPCODE_W  = control_sequencer_pkg::OPCODE_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                ZERO,
  input  logic                MEM_READY,
  output logic                LOAD_REG,
  output load_sel_t           LOAD_SELECT,
  output logic                ADDR_SEL,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic                PC_INC,
  output alu_op_t             ALU_OP,
  output logic                HALTED
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                TRAP
`endif
);

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH, S_IR_LOAD, S_DECODE_WAIT, S_DECODE,
    S_EXEC_MEM, S_WRITEBACK, S_HALT, S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, cls_op;
  logic                is_mem, is_store, is_alu, is_jump, is_illegal;
  logic                is_halt, jump_taken;
  ctrl_out_t           out_q, out_d;

  // OPCODE is only trusted in DECODE; later states use the copy latched there.
  assign cls_op = (state_q == S_DECODE) ? OPCODE : op_q;

  op_classifier #(.OPCODE_W(OPCODE_W)) u_cls (
    .opcode     (cls_op),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_alu     (is_alu),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  assign is_halt    = (cls_op == OPCODE_W'(OP_HALT));
  assign jump_taken = is_jump && ((cls_op == OPCODE_W'(OP_JMP)) || ZERO);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (state_q == S_DECODE) op_q <= OPCODE;
    end
  end

  // A FETCH cycle with MEM_RD low (first cycle out of reset, or the PC-load
  // pulse after a taken jump) has no request outstanding, so MEM_READY is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:       if (out_q.mem_rd && MEM_READY) state_d = S_IR_LOAD;
      S_IR_LOAD:     state_d = S_DECODE_WAIT;
      S_DECODE_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)                      state_d = S_HALT;
        else if (is_mem)                  state_d = S_EXEC_MEM;
        else if (is_illegal && TRAP_EN)   state_d = S_TRAP;
        else                              state_d = S_FETCH;
      end
      S_EXEC_MEM:    if (MEM_READY) state_d = is_store ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK:   state_d = S_FETCH;
      default:       state_d = state_q;
    endcase
  end

  // Outputs are computed for the state being entered and registered, so
  // they line up with state_q without any combinational path from inputs.
  always_comb begin
    out_d          = '0;
    out_d.load_sel = LOAD_NONE;
    out_d.alu_op   = ALU_PASS;
    case (state_d)
      S_FETCH: begin
        if (state_q == S_DECODE && jump_taken) begin
          out_d.load_reg = 1'b1;
          out_d.load_sel = LOAD_PC;
        end else begin
          out_d.mem_rd = 1'b1;
        end
      end
      S_IR_LOAD: begin
        out_d.load_reg = 1'b1;
        out_d.load_sel = LOAD_IR;
        out_d.pc_inc   = 1'b1;
      end
      S_EXEC_MEM: begin
        out_d.addr_sel = 1'b1;
        out_d.mem_wr   = is_store;
        out_d.mem_rd   = !is_store;
      end
      S_WRITEBACK: begin
        out_d.load_reg = 1'b1;
        out_d.load_sel = LOAD_ACC;
        out_d.alu_op   = is_alu ? alu_of(cls_op) : ALU_PASS;
      end
      S_HALT: out_d.halted = 1'b1;
      S_TRAP: begin
        out_d.halted = 1'b1;
        out_d.trap   = 1'b1;
      end
      default: ;
    endcase
  end

  assign LOAD_REG    = out_q.load_reg;
  assign LOAD_SELECT = out_q.load_sel;
  assign ADDR_SEL    = out_q.addr_sel;
  assign MEM_RD      = out_q.mem_rd;
  assign MEM_WR      = out_q.mem_wr;
  assign PC_INC      = out_q.pc_inc;
  assign ALU_OP      = out_q.alu_op;
  assign HALTED      = out_q.halted;
`ifdef ILLEGAL_OP_TRAP_EN
  assign TRAP        = out_q.trap;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: an instruction-level model expands each instruction into its
// expected per-cycle control trace; every cycle is compared against the DUT.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] OPCODE = '0;
  logic       ZERO = 1'b0;
  logic       MEM_READY = 1'b0;
  logic       LOAD_REG, ADDR_SEL, MEM_RD, MEM_WR, PC_INC, HALTED;
  load_sel_t  LOAD_SELECT;
  alu_op_t    ALU_OP;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       TRAP;
`endif

  always #5 CLK = ~CLK;

  control_sequencer dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .LOAD_REG(LOAD_REG), .LOAD_SELECT(LOAD_SELECT), .ADDR_SEL(ADDR_SEL),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .PC_INC(PC_INC), .ALU_OP(ALU_OP),
    .HALTED(HALTED)
`ifdef ILLEGAL_OP_TRAP_EN
    , .TRAP(TRAP)
`endif
  );

  typedef struct {
    bit lr; load_sel_t ls; bit as; bit rd; bit wr; bit pi; alu_op_t alu; bit h; bit t;
  } exp_t;
  typedef struct { bit rdy; bit z; logic [4:0] op; } inp_t;

  exp_t eq[$];
  inp_t iq[$];
  int checks = 0, errors = 0, cyc = 0;
  int n_rd, n_wr, n_ir, n_pc, n_acc, n_lr, n_pi, n_h, n_hstrobe;
  alu_op_t last_alu = ALU_PASS;
  int fstart[$];
  bit prev_fs = 1'b0;

  function automatic exp_t quiet();
    exp_t e;
    e.lr = 0; e.ls = LOAD_NONE; e.as = 0; e.rd = 0; e.wr = 0; e.pi = 0;
    e.alu = ALU_PASS; e.h = 0; e.t = 0;
    return e;
  endfunction

  // Cycle where OPCODE/ZERO are irrelevant: drive junk on them.
  function automatic void push_j(exp_t e, bit rdy);
    inp_t in;
    in.rdy = rdy; in.z = 1'($urandom_range(0, 1)); in.op = 5'($urandom_range(0, 31));
    eq.push_back(e); iq.push_back(in);
  endfunction

  function automatic void push_d(exp_t e, bit z, logic [4:0] op);
    inp_t in;
    in.rdy = 1'b1; in.z = z; in.op = op;
    eq.push_back(e); iq.push_back(in);
  endfunction

  function automatic void push_stop(int n, bit trap);
    exp_t e;
    e = quiet(); e.h = 1; e.t = trap;
    for (int i = 0; i < n; i++) push_j(e, 1'($urandom_range(0, 1)));
  endfunction

  // fw/mw: extra wait cycles before MEM_READY in fetch / memory phase.
  function automatic void push_instr(logic [4:0] op, bit z, int fw, int mw);
    exp_t e;
    for (int i = 0; i <= fw; i++) begin e = quiet(); e.rd = 1; push_j(e, i == fw); end
    e = quiet(); e.lr = 1; e.ls = LOAD_IR; e.pi = 1; push_j(e, 1'b1);
    push_j(quiet(), 1'b1);
    push_d(quiet(), z, op);
    case (op)
      5'h07, 5'h08: if (op == 5'h07 || z) begin
        e = quiet(); e.lr = 1; e.ls = LOAD_PC; push_j(e, 1'b1);
      end
      5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06: begin
        for (int j = 0; j <= mw; j++) begin
          e = quiet(); e.as = 1; e.wr = (op == 5'h02); e.rd = (op != 5'h02);
          push_j(e, j == mw);
        end
        if (op != 5'h02) begin
          e = quiet(); e.lr = 1; e.ls = LOAD_ACC;
          case (op)
            5'h03: e.alu = ALU_ADD;
            5'h04: e.alu = ALU_SUB;
            5'h05: e.alu = ALU_AND;
            5'h06: e.alu = ALU_OR;
            default: e.alu = ALU_PASS;
          endcase
          push_j(e, 1'b1);
        end
      end
      5'h1F: push_stop(25, 1'b0);
      5'h00: ;
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        push_stop(25, 1'b1);
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic clr();
    n_rd = 0; n_wr = 0; n_ir = 0; n_pc = 0; n_acc = 0; n_lr = 0; n_pi = 0;
    n_h = 0; n_hstrobe = 0;
  endtask

  // Run n queued cycles (all if n < 0), comparing each; leftovers are dropped.
  task automatic run(input int n);
    int k;
    inp_t in; exp_t e; bit bad, fs, tr;
    k = (n < 0 || n > eq.size()) ? eq.size() : n;
    for (int i = 0; i < k; i++) begin
      @(negedge CLK);
      in = iq.pop_front(); e = eq.pop_front();
      MEM_READY = in.rdy; ZERO = in.z; OPCODE = in.op;
`ifdef ILLEGAL_OP_TRAP_EN
      tr = TRAP;
`else
      tr = 1'b0;
`endif
      bad = (LOAD_REG !== e.lr) || (LOAD_SELECT !== e.ls) || (ADDR_SEL !== e.as) ||
            (MEM_RD !== e.rd) || (MEM_WR !== e.wr) || (PC_INC !== e.pi) ||
            (ALU_OP !== e.alu) || (HALTED !== e.h) || (tr !== e.t);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL trace cyc %0d: got lr=%b ls=%0d as=%b rd=%b wr=%b pi=%b alu=%0d h=%b t=%b, want lr=%b ls=%0d as=%b rd=%b wr=%b pi=%b alu=%0d h=%b t=%b",
                 cyc, LOAD_REG, LOAD_SELECT, ADDR_SEL, MEM_RD, MEM_WR, PC_INC, ALU_OP, HALTED, tr,
                 e.lr, e.ls, e.as, e.rd, e.wr, e.pi, e.alu, e.h, e.t);
      end
      n_rd += int'(MEM_RD); n_wr += int'(MEM_WR); n_pi += int'(PC_INC);
      n_lr += int'(LOAD_REG); n_h += int'(HALTED);
      if (LOAD_REG && LOAD_SELECT == LOAD_IR) n_ir++;
      if (LOAD_REG && LOAD_SELECT == LOAD_PC) n_pc++;
      if (LOAD_REG && LOAD_SELECT == LOAD_ACC) begin n_acc++; last_alu = ALU_OP; end
      if (HALTED && (LOAD_REG || MEM_RD || MEM_WR || PC_INC)) n_hstrobe++;
      fs = MEM_RD && !ADDR_SEL;
      if (fs && !prev_fs) fstart.push_back(cyc);
      prev_fs = fs;
      cyc++;
    end
    eq.delete(); iq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; MEM_READY = 1'b1;
    @(negedge CLK);
    check("rst_load_reg", int'(LOAD_REG), 0);
    check("rst_load_sel", int'(LOAD_SELECT), int'(LOAD_NONE));
    check("rst_addr_sel", int'(ADDR_SEL), 0);
    check("rst_mem_rd", int'(MEM_RD), 0);
    check("rst_mem_wr", int'(MEM_WR), 0);
    check("rst_pc_inc", int'(PC_INC), 0);
    check("rst_alu_op", int'(ALU_OP), int'(ALU_PASS));
    check("rst_halted", int'(HALTED), 0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("rst_trap", int'(TRAP), 0);
`endif
    RST = 1'b0; MEM_READY = 1'b0;
    prev_fs = 1'b0;
    cyc++;
  endtask

  initial begin
    do_reset();
    clr(); push_instr(5'h00, 0, 2, 0); run(-1);
    check("fetch_rd_cycles", n_rd, 3);
    check("fetch_ir_load", n_ir, 1);
    check("fetch_pc_inc", n_pi, 1);

    clr(); push_instr(5'h03, 0, 0, 0); run(-1);
    check("add_acc_load", n_acc, 1);
    check("add_alu_op", int'(last_alu), int'(ALU_ADD));
    check("add_mem_rd", n_rd, 2);
    push_instr(5'h00, 0, 0, 0); run(-1);
    check("add_fetch_to_fetch", fstart[fstart.size()-1] - fstart[fstart.size()-2], 6);

    clr(); push_instr(5'h08, 1, 1, 0); run(-1);
    check("jz_taken_pc_load", n_pc, 1);
    clr(); push_instr(5'h08, 0, 0, 0); run(-1);
    check("jz_not_pc_load", n_pc, 0);
    check("jz_not_load_reg", n_lr, 1);
    clr(); push_instr(5'h07, 0, 0, 0); run(-1);
    check("jmp_pc_load", n_pc, 1);

    push_instr(5'h04, 0, 1, 2); push_instr(5'h05, 1, 0, 1);
    push_instr(5'h06, 0, 2, 0); run(-1);
    clr(); push_instr(5'h01, 0, 0, 0); run(-1);
    check("load_acc", n_acc, 1);
    check("load_alu_pass", int'(last_alu), int'(ALU_PASS));

    clr(); push_instr(5'h02, 0, 0, 1); run(-1);
    check("store_wr_cycles", n_wr, 2);
    check("store_rd_cycles", n_rd, 1);
    check("store_no_wb", n_acc, 0);

    clr(); push_instr(5'h10, 0, 0, 0); run(-1);
`ifdef ILLEGAL_OP_TRAP_EN
    check("illegal_trap_halted", n_h, 25);
    do_reset();
`else
    check("illegal_nop_load_reg", n_lr, 1);
    check("illegal_nop_halted", n_h, 0);
`endif

    // Reset landing two cycles into a memory read.
    clr(); push_instr(5'h01, 0, 0, 5); run(6);
    check("pre_rst_exec_rd", int'(MEM_RD), 1);
    do_reset();

    clr(); push_instr(5'h1F, 0, 0, 0); run(-1);
    check("halt_cycles_ge20", int'(n_h >= 20), 1);
    check("halt_strobes", n_hstrobe, 0);
    do_reset();
    clr(); push_instr(5'h03, 0, 1, 0); push_instr(5'h00, 0, 0, 0); run(-1);
    check("restart_acc", n_acc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 19: CPU word width, matching the shared constants package.
REQ-002 Parameter OPCODE_W, default 5: opcode width, equal to the top 5 bits of the instruction word.
REQ-003 Port CLK  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port RST  in  1: synchronous, active-high reset.
REQ-005 Port OPCODE  in  OPCODE_W: registered opcode from the instruction register, valid 2 cycles after an IR load.
REQ-006 Port ZERO  in  1: accumulator-zero flag.
REQ-007 Port MEM_READY  in  1: memory completion strobe, one cycle per access.
REQ-008 Port LOAD_REG  out  1: register load strobe.
REQ-009 Port LOAD_SELECT  out  load_sel_t: load target, one of LOAD_NONE, LOAD_IR, LOAD_PC, LOAD_ACC.
REQ-010 Port ADDR_SEL  out  1: memory address source; 0 = PC, 1 = IR address field.
REQ-011 Port MEM_RD / MEM_WR  out  1 each: memory read and write requests.
REQ-012 Port PC_INC  out  1: program counter increment strobe.
REQ-013 Port ALU_OP  out  alu_op_t: ALU operation, one of PASS, ADD, SUB, AND, OR.
REQ-014 Port HALTED  out  1: high while in the HALT or TRAP state.
REQ-015 Port TRAP  out  1: illegal-opcode flag; exists only when ILLEGAL_OP_TRAP_EN is defined.

Function
REQ-016 The FSM SHALL have the states FETCH, IR_LOAD, DECODE_WAIT, DECODE, EXEC_MEM, WRITEBACK, HALT and TRAP.
REQ-017 FETCH SHALL drive MEM_RD=1 and ADDR_SEL=0, and SHALL hold until MEM_READY=1, then go to IR_LOAD.
REQ-018 IR_LOAD SHALL pulse LOAD_REG=1 with LOAD_SELECT=LOAD_IR and PC_INC=1 for exactly one cycle, then go to DECODE_WAIT.
REQ-019 DECODE_WAIT SHALL last one cycle, covering the IR's two-stage latency; OPCODE is sampled only in DECODE.
REQ-020 The opcode map SHALL be: NOP=0x00, LOAD=0x01, STORE=0x02, ADD=0x03, SUB=0x04, AND=0x05, OR=0x06, JMP=0x07, JZ=0x08, HALT=0x1F.
REQ-021 In DECODE, NOP SHALL go to FETCH; JMP SHALL pulse LOAD_REG with LOAD_PC, then go to FETCH.
REQ-022 In DECODE, JZ SHALL do the same as JMP only when ZERO=1; otherwise it SHALL behave as NOP.
REQ-023 In DECODE, LOAD/ADD/SUB/AND/OR SHALL go to EXEC_MEM; STORE SHALL go to EXEC_MEM; HALT SHALL go to HALT.
REQ-024 EXEC_MEM SHALL drive ADDR_SEL=1, with MEM_WR=1 for STORE and MEM_RD=1 otherwise, and SHALL hold until MEM_READY=1.
REQ-025 On MEM_READY in EXEC_MEM, STORE SHALL go to FETCH and all other opcodes SHALL go to WRITEBACK.
REQ-026 WRITEBACK SHALL pulse LOAD_REG with LOAD_ACC for one cycle, with ALU_OP=PASS for LOAD and the matching op otherwise, then go to FETCH.
REQ-027 MEM_RD and MEM_WR SHALL never be high in the same cycle.
REQ-028 LOAD_REG SHALL be high only alongside a LOAD_SELECT other than LOAD_NONE.
REQ-029 MEM_READY outside FETCH/EXEC_MEM SHALL be ignored.
REQ-030 HALT SHALL be absorbing until RST, with all strobes low.
REQ-031 All outputs SHALL be registered, or decoded from the state register only.

Reset
REQ-032 RST=1 at any clock edge, including mid-access, SHALL force state FETCH and outputs LOAD_REG=0, LOAD_SELECT=LOAD_NONE, ADDR_SEL=0, MEM_WR=0, PC_INC=0, ALU_OP=PASS, HALTED=0, TRAP=0, with MEM_RD asserting in the first cycle after RST deasserts.

Configuration
REQ-033 With ILLEGAL_OP_TRAP_EN defined, an unlisted opcode in DECODE SHALL go to TRAP, which asserts TRAP=1 and HALTED=1 and is absorbing until RST.
REQ-034 Without ILLEGAL_OP_TRAP_EN, an unlisted opcode SHALL execute as NOP and the TRAP port SHALL be absent.

Structure
REQ-035 load_sel_t, alu_op_t, the opcode enum, WORD_SIZE and OPCODE_W SHALL live in the shared constants package.
REQ-036 The state enum SHALL be local to the module.
REQ-037 Opcode classification SHALL be one combinational sub-module, op_classifier (opcode -> is_mem, is_store, is_alu, is_jump, is_illegal).

Verification
REQ-038 Reset then MEM_READY on the 3rd cycle SHALL give MEM_RD high for 3 cycles, then LOAD_REG with LOAD_IR and PC_INC for exactly 1 cycle.
REQ-039 OPCODE=0x03 with MEM_READY=1 on the first EXEC_MEM cycle SHALL give ADDR_SEL=1 with MEM_RD, then LOAD_ACC with ALU_OP=ADD, then return to FETCH; fetch to fetch SHALL take 6 cycles.
REQ-040 OPCODE=0x08: ZERO=1 SHALL pulse LOAD_PC; ZERO=0 SHALL pulse no LOAD_REG and return to FETCH.
REQ-041 OPCODE=0x02 SHALL give MEM_WR=1 with MEM_RD=0 and no WRITEBACK.
REQ-042 OPCODE=0x1F SHALL give HALTED=1 stable for at least 20 cycles with no strobes; a subsequent RST SHALL restart FETCH.
REQ-043 OPCODE=0x10 SHALL give TRAP=1 when ILLEGAL_OP_TRAP_EN is defined and a NOP otherwise; RST asserted in EXEC_MEM SHALL drop MEM_RD on the next edge.
